// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display driver and the scan-bus monitor.
// All segment codes are active-low, bit order g..a.
package seg7_pkg;

    localparam int unsigned AN_W       = 4;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned NUM_DIGITS = 10;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [AN_W-1:0] AN_0    = 4'b1110;
    localparam logic [AN_W-1:0] AN_1    = 4'b1101;
    localparam logic [AN_W-1:0] AN_2    = 4'b1011;
    localparam logic [AN_W-1:0] AN_3    = 4'b0111;
    localparam logic [AN_W-1:0] AN_NONE = 4'b1111;

    // One sample of the multiplexed display bus
    typedef struct packed {
        logic [AN_W-1:0]  an;
        logic [SEG_W-1:0] seg;
    } scan_bus_t;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HELD
    } scan_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
        case (bcd)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of bcd_to_seg: recovers the BCD value from an active-low
// segment pattern and flags any pattern that is not one of the ten digits.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0]       seg,
    output logic             valid_c,
    output logic [BCD_W-1:0] bcd_c
);

    // Search the shared encode table so both ends of the bus stay in step
    always_comb begin
        valid_c = 1'b0;
        bcd_c   = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_to_seg(BCD_W'(i)) == seg) begin
                valid_c = 1'b1;
                bcd_c   = BCD_W'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitor for the multiplexed 4-digit common-anode display bus: waits for each digit
// dwell to settle, decodes it back to BCD and publishes complete 4-digit frames.
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic [AN_W-1:0]  an_in,
    input  logic [SEG_W-1:0] seg_in,
    output logic [BCD_W-1:0] digit0,
    output logic [BCD_W-1:0] digit1,
    output logic [BCD_W-1:0] digit2,
    output logic [BCD_W-1:0] digit3,
    output logic [AN_W-1:0]  dp_out,
    output logic             frame_valid,
    output logic             seg_err,
    output logic             an_err,
    output logic             scan_timeout
);

    localparam int unsigned SET_W = $clog2(STABLE_CYCLES);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned POS_W = $clog2(AN_W);

    scan_bus_t                    sync1_q, sync2_q, cmp_q;
    scan_state_t                  state_q, state_d;
    logic [SET_W-1:0]             settle_q, settle_d;
    logic [TO_W-1:0]              tcnt_q, tcnt_d;
    logic [AN_W-1:0]              mask_q, mask_d;
    logic [AN_W-1:0]              sdp_q, sdp_d;
    logic [AN_W-1:0]              dp_q, dp_d;
    logic [AN_W-1:0][BCD_W-1:0]   shadow_q, shadow_d;
    logic [AN_W-1:0][BCD_W-1:0]   digits_q, digits_d;
    logic                         frame_q, frame_d;
    logic                         seg_err_q, seg_err_d;
    logic                         an_err_q, an_err_d;
    logic                         timeout_q, timeout_d;

    logic                         bus_changed;
    logic                         evaluate;
    logic                         capture;
    logic [AN_W-1:0]              an_low;
    logic [POS_W:0]               low_cnt;
    logic [POS_W-1:0]             pos;
    logic                         dec_valid;
    logic [BCD_W-1:0]             dec_bcd;

    // Two-flop synchronizer plus compare register; blank bus (all ones) out of reset
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            cmp_q   <= '1;
        end else begin
            sync1_q <= scan_bus_t'({an_in, seg_in});
            sync2_q <= sync1_q;
            cmp_q   <= sync2_q;
        end
    end

    assign bus_changed = (sync2_q != cmp_q);

    seg7_decode u_decode (
        .seg     (cmp_q.seg[6:0]),
        .valid_c (dec_valid),
        .bcd_c   (dec_bcd)
    );

    // Count active anodes and locate the (last) low one
    always_comb begin
        an_low  = ~cmp_q.an;
        low_cnt = '0;
        pos     = '0;
        for (int unsigned i = 0; i < AN_W; i++) begin
            if (an_low[i]) begin
                low_cnt = low_cnt + 1'b1;
                pos     = POS_W'(i);
            end
        end
    end

    // Settle FSM, capture, timeout and frame assembly
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        evaluate  = 1'b0;
        capture   = 1'b0;
        tcnt_d    = tcnt_q;
        mask_d    = mask_q;
        shadow_d  = shadow_q;
        sdp_d     = sdp_q;
        digits_d  = digits_q;
        dp_d      = dp_q;
        frame_d   = 1'b0;
        seg_err_d = 1'b0;
        an_err_d  = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            ST_WAIT, ST_HELD: begin
                if (bus_changed) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            ST_SETTLE: begin
                if (bus_changed) begin
                    settle_d = '0;
                end else if (settle_q == SET_W'(STABLE_CYCLES - 1)) begin
                    evaluate = 1'b1;
                    state_d  = ST_HELD;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        if (evaluate) begin
            if (low_cnt > (POS_W + 1)'(1)) begin
                an_err_d = 1'b1;
            end else if (low_cnt == (POS_W + 1)'(1)) begin
                if (dec_valid) begin
                    capture       = 1'b1;
                    shadow_d[pos] = dec_bcd;
                    sdp_d[pos]    = ~cmp_q.seg[SEG_W-1];
                    mask_d[pos]   = 1'b1;
                end else begin
                    seg_err_d   = 1'b1;
                    mask_d[pos] = 1'b0;
                end
            end
        end

        // A capture on the edge the timeout would fire takes priority
        if (capture) begin
            tcnt_d    = '0;
            timeout_d = 1'b0;
        end else if (tcnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            tcnt_d = tcnt_q + 1'b1;
            if (tcnt_d == TO_W'(TIMEOUT_CYCLES)) begin
                timeout_d = 1'b1;
                mask_d    = '0;
            end
        end

        if (mask_d == '1) begin
            frame_d  = 1'b1;
            digits_d = shadow_d;
            dp_d     = sdp_d;
            mask_d   = '0;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_WAIT;
            settle_q  <= '0;
            tcnt_q    <= '0;
            mask_q    <= '0;
            shadow_q  <= '0;
            sdp_q     <= '0;
            digits_q  <= '0;
            dp_q      <= '0;
            frame_q   <= 1'b0;
            seg_err_q <= 1'b0;
            an_err_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            tcnt_q    <= tcnt_d;
            mask_q    <= mask_d;
            shadow_q  <= shadow_d;
            sdp_q     <= sdp_d;
            digits_q  <= digits_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
            seg_err_q <= seg_err_d;
            an_err_q  <= an_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign digit0       = digits_q[0];
    assign digit1       = digits_q[1];
    assign digit2       = digits_q[2];
    assign digit3       = digits_q[3];
    assign dp_out       = dp_q;
    assign frame_valid  = frame_q;
    assign seg_err      = seg_err_q;
    assign an_err       = an_err_q;
    assign scan_timeout = timeout_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scan scenarios plus random dwells, every cycle
// compared against a dwell-level reference model of the display-bus monitor.
module tb_seg_scan_decoder;

    localparam int unsigned STABLE = 4;
    localparam int unsigned TMO    = 64;
    // A dwell held long enough is judged this many edges after its first drive
    localparam int EVAL_DELAY = STABLE + 3;

    typedef struct {
        longint      due;
        logic [11:0] bus;
    } pend_t;

    logic       mclk   = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] an_in  = 4'hf;
    logic [7:0] seg_in = 8'hff;
    logic [3:0] digit0, digit1, digit2, digit3, dp_out;
    logic       frame_valid, seg_err, an_err, scan_timeout;

    always #5 mclk = ~mclk;

    seg_scan_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .mclk         (mclk),
        .rst_n        (rst_n),
        .an_in        (an_in),
        .seg_in       (seg_in),
        .digit0       (digit0),
        .digit1       (digit1),
        .digit2       (digit2),
        .digit3       (digit3),
        .dp_out       (dp_out),
        .frame_valid  (frame_valid),
        .seg_err      (seg_err),
        .an_err       (an_err),
        .scan_timeout (scan_timeout)
    );

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int errors = 0;
    int checks = 0;

    logic [3:0][3:0] m_digit, m_shadow;
    logic [3:0]      m_dp, m_sdp, m_mask;
    logic            m_frame, m_segerr, m_anerr, m_to;
    int              m_tsince;
    longint          cyc = 0;
    logic [11:0]     prev_bus;
    pend_t           pq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mk(input int d, input bit dp);
        return {~dp, seg_tab[d]};
    endfunction

    task automatic model_reset();
        m_digit  = '0;
        m_shadow = '0;
        m_dp     = '0;
        m_sdp    = '0;
        m_mask   = '0;
        m_frame  = 1'b0;
        m_segerr = 1'b0;
        m_anerr  = 1'b0;
        m_to     = 1'b0;
        m_tsince = 0;
        prev_bus = 12'hfff;
        pq.delete();
    endtask

    // One clock edge of the monitor; judge is set when a settled dwell is due
    task automatic model_edge(input logic [11:0] bus, input bit judge);
        int  nlow;
        int  k;
        int  v;
        bit  cap;
        m_frame  = 1'b0;
        m_segerr = 1'b0;
        m_anerr  = 1'b0;
        cap      = 1'b0;
        if (judge) begin
            nlow = 0;
            k    = 0;
            for (int i = 0; i < 4; i++) begin
                if (!bus[8+i]) begin
                    nlow++;
                    k = i;
                end
            end
            if (nlow > 1) begin
                m_anerr = 1'b1;
            end else if (nlow == 1) begin
                v = -1;
                for (int d = 0; d < 10; d++) if (bus[6:0] == seg_tab[d]) v = d;
                if (v >= 0) begin
                    m_shadow[k] = 4'(v);
                    m_sdp[k]    = ~bus[7];
                    m_mask[k]   = 1'b1;
                    cap         = 1'b1;
                end else begin
                    m_segerr  = 1'b1;
                    m_mask[k] = 1'b0;
                end
            end
        end
        if (cap) begin
            m_tsince = 0;
            m_to     = 1'b0;
        end else if (m_tsince < int'(TMO)) begin
            m_tsince++;
            if (m_tsince == int'(TMO)) begin
                m_to   = 1'b1;
                m_mask = '0;
            end
        end
        if (m_mask == 4'hf) begin
            m_frame = 1'b1;
            m_digit = m_shadow;
            m_dp    = m_sdp;
            m_mask  = '0;
        end
    endtask

    task automatic run_dwell(input logic [3:0] an, input logic [7:0] seg, input int len);
        pend_t p;
        an_in  = an;
        seg_in = seg;
        if ({an, seg} != prev_bus && len > int'(STABLE)) begin
            p.due = cyc + EVAL_DELAY;
            p.bus = {an, seg};
            pq.push_back(p);
        end
        prev_bus = {an, seg};
        for (int j = 1; j <= len; j++) begin
            @(posedge mclk);
            cyc++;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                p = pq.pop_front();
                model_edge(p.bus, 1'b1);
            end else begin
                model_edge(12'hfff, 1'b0);
            end
            @(negedge mclk);
            check("pulses", {frame_valid, seg_err, an_err, scan_timeout},
                  {m_frame, m_segerr, m_anerr, m_to});
            check("digits_dp", {digit3, digit2, digit1, digit0, dp_out}, {m_digit, m_dp});
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        an_in  = 4'hf;
        seg_in = 8'hff;
        @(negedge mclk);
        @(negedge mclk);
        model_reset();
        check("reset_outputs",
              {digit3, digit2, digit1, digit0, dp_out, frame_valid, seg_err, an_err, scan_timeout}, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] an;
        logic [7:0] seg;
        int         r, len;

        model_reset();
        do_reset();

        // Full scan 1,2,3,4 with dp on position 3
        run_dwell(4'b1110, mk(1, 0), 20);
        run_dwell(4'b1101, mk(2, 0), 20);
        run_dwell(4'b1011, mk(3, 0), 20);
        run_dwell(4'b0111, mk(4, 1), 20);
        check("scan_digits", {digit3, digit2, digit1, digit0}, 16'h4321);
        check("scan_dp", dp_out, 4'b1000);

        // Segments changing faster than the settle window, then a 6-cycle hold
        for (int i = 0; i < 4; i++) run_dwell(4'b1110, mk(5 + (i % 2), 0), 3);
        run_dwell(4'b1110, mk(7, 0), 6);
        run_dwell(4'b1111, 8'hff, 10);

        // Non-digit pattern on position 2, then a repaired scan
        run_dwell(4'b1011, {1'b1, 7'b0111111}, 20);
        check("digits_held", {digit3, digit2, digit1, digit0}, 16'h4321);
        run_dwell(4'b1101, mk(8, 0), 20);
        run_dwell(4'b0111, mk(0, 0), 20);
        run_dwell(4'b1011, mk(9, 1), 20);

        // Two anodes low, then a blank bus
        run_dwell(4'b1100, mk(3, 0), 20);
        run_dwell(4'b1111, mk(3, 0), 20);

        // Partial frame then a stall long enough to time out
        do_reset();
        run_dwell(4'b1110, mk(7, 0), 12);
        run_dwell(4'b1101, mk(8, 0), 12);
        run_dwell(4'b1111, 8'hff, 70);
        check("timeout_set", scan_timeout, 1'b1);
        run_dwell(4'b1110, mk(9, 0), 12);
        run_dwell(4'b1101, mk(0, 0), 12);
        run_dwell(4'b1011, mk(5, 0), 12);
        run_dwell(4'b0111, mk(6, 1), 12);
        check("timeout_clear", scan_timeout, 1'b0);
        check("after_timeout_digits", {digit3, digit2, digit1, digit0}, 16'h6509);

        // Reset after three positions: the fourth alone must not complete a frame
        run_dwell(4'b1110, mk(2, 0), 12);
        run_dwell(4'b1101, mk(2, 0), 12);
        run_dwell(4'b1011, mk(2, 0), 12);
        do_reset();
        run_dwell(4'b0111, mk(2, 0), 20);
        check("rst_midframe", {digit3, digit2, digit1, digit0, dp_out, frame_valid}, 0);

        // Random dwells: mostly valid digits, some garbage, blanks, stalls and resets
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                an  = ~(4'b0001 << $urandom_range(0, 3));
                seg = mk(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
            end else if (r < 80) begin
                an  = ~(4'b0001 << $urandom_range(0, 3));
                seg = 8'($urandom);
            end else if (r < 90) begin
                an  = 4'($urandom);
                seg = 8'($urandom);
            end else begin
                an  = 4'hf;
                seg = 8'($urandom);
            end
            if ({an, seg} == prev_bus) seg = seg ^ 8'h80;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(6, 20));
            if (r >= 97) len = 70;
            if (r == 96) do_reset();
            run_dwell(an, seg, len);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
